uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority-vote bit decisions and a one-word holding register.
// Optional parity reception is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_en,
    input  logic                 rx_in,
    input  logic [15:0]          div,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LO   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_HI   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                 r_state;
    logic                   r_sync1, r_sync2, r_sync_d;
    logic [15:0]            r_div_cnt;
    logic [TW-1:0]          r_tick_cnt;
    logic [3:0]             r_bit_cnt;
    logic                   r_s0, r_s1;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_ferr;
    logic                   r_done;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr_o;
    logic                   r_overrun;

    logic [15:0] w_div_last;
    logic        w_tick;
    logic        w_fall;
    logic        w_maj;
    logic        w_decide;
    logic        w_bit_end;
    logic        w_accept;

    assign w_div_last = (div == 16'd0) ? 16'd0 : div - 16'd1;
    // >= lets the divider recover immediately if div shrinks mid-count
    assign w_tick     = (r_div_cnt >= w_div_last);
    assign w_fall     = r_sync_d & ~r_sync2;
    assign w_maj      = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_decide   = w_tick && (r_tick_cnt == TICK_HI);
    assign w_bit_end  = w_tick && (r_tick_cnt == TICK_LAST);
    assign w_accept   = r_valid & rx_ready;

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr_o;
    assign overrun   = r_overrun;
    assign busy      = (r_state != StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= rx_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div_cnt <= 16'd0;
        end else if (r_state == StIdle && rx_en && w_fall) begin
            r_div_cnt <= 16'd0;
        end else if (w_tick) begin
            r_div_cnt <= 16'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic r_perr_o;
    assign parity_err = r_perr_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perr   <= 1'b0;
            r_perr_o <= 1'b0;
        end else begin
            if (r_state == StIdle && rx_en && w_fall) begin
                r_perr <= 1'b0;
            end else if (rx_en && !r_done && r_state == StParity && w_decide) begin
                r_perr <= ((^r_shift) ^ w_maj) != parity_odd;
            end
            if (r_done && rx_en && (!r_valid || rx_ready)) begin
                r_perr_o <= r_perr;
            end
        end
    end
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = parity_odd;
    assign parity_err          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr_o   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // Holding register: a completed frame is dropped if the held word is not taken now
            if (r_done && rx_en) begin
                if (!r_valid || rx_ready) begin
                    r_data   <= r_shift;
                    r_ferr_o <= r_ferr;
                    r_valid  <= 1'b1;
                    if (r_valid) begin
                        r_overrun <= 1'b0;
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end

            if (!rx_en || r_done) begin
                r_state <= StIdle;
                r_done  <= 1'b0;
            end else if (r_state == StIdle) begin
                if (w_fall) begin
                    r_state    <= StStart;
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= 4'd0;
                    r_ferr     <= 1'b0;
                end
            end else if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
                if (r_tick_cnt == TICK_LO) begin
                    r_s0 <= r_sync2;
                end
                if (r_tick_cnt == TICK_MID) begin
                    r_s1 <= r_sync2;
                end
                unique case (r_state)
                    StStart: begin
                        if (w_decide && w_maj) begin
                            r_state <= StIdle;
                        end else if (w_bit_end) begin
                            r_state <= StData;
                        end
                    end
                    StData: begin
                        if (w_decide) begin
                            r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_bit_end && r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= StParity;
`else
                            r_state   <= StStop;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (w_bit_end) begin
                            r_state <= StStop;
                        end
                    end
`endif
                    StStop: begin
                        if (w_decide) begin
                            if (!w_maj) begin
                                r_ferr <= 1'b1;
                            end
                            if (r_bit_cnt == LAST_STOP) begin
                                r_done <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule
